// File: rtl/rsnn_pkg.sv
// Shared types and helpers for the recurrent spiking layer.
// Holds the sweep FSM state type, the saturating adder and the
// population counter used for the lateral (RSNN_LATERAL_EN) term.
package rsnn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } rsnn_state_e;

    // Add two unsigned values and clamp the result to 2^width-1.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned width);
        logic [32:0] sum;
        logic [32:0] limit;
        sum   = {1'b0, a} + {1'b0, b};
        limit = (33'd1 << width) - 33'd1;
        return (sum > limit) ? limit[31:0] : sum[31:0];
    endfunction

    // Count the set bits among the lowest n bits of vec (n = neuron count).
    function automatic int unsigned popcount(input logic [31:0] vec,
                                             input int unsigned n);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < n && vec[i]) cnt++;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/rsnn_if.sv
// Bus bundle for the recurrent spiking layer: timestep control,
// per-timestep configuration and the spike result handshake.
interface rsnn_if #(
    parameter int N_NEURONS = 4,
    parameter int WIDTH     = 8,
    parameter int REFR_W    = 8
);
    logic                       enable;
    logic                       tick;
    logic [N_NEURONS*WIDTH-1:0] ext_current;
    logic [WIDTH-1:0]           threshold;
    logic [WIDTH-1:0]           decay;
    logic [REFR_W-1:0]          refractory_period;
    logic [WIDTH-1:0]           self_scale;
    logic [WIDTH-1:0]           lateral_scale;
    logic [N_NEURONS-1:0]       spike_out;
    logic                       spike_valid;
    logic                       busy;
    logic                       overrun;

    modport master (
        output enable, tick, ext_current, threshold, decay,
               refractory_period, self_scale, lateral_scale,
        input  spike_out, spike_valid, busy, overrun
    );

    modport slave (
        input  enable, tick, ext_current, threshold, decay,
               refractory_period, self_scale, lateral_scale,
        output spike_out, spike_valid, busy, overrun
    );
endinterface

// File: rtl/rsnn_neuron_update.sv
// Combinational LIF update for one neuron of the layer.
// Lateral feedback inputs exist only when RSNN_LATERAL_EN is defined.
module rsnn_neuron_update
    import rsnn_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int REFR_W = 8,
    parameter int CNT_W  = 3
) (
    input  logic [WIDTH-1:0]  mem,
    input  logic [REFR_W-1:0] refr,
    input  logic [WIDTH-1:0]  ext,
    input  logic              prev_spike,
`ifdef RSNN_LATERAL_EN
    input  logic [CNT_W-1:0]  lat_count,
    input  logic [WIDTH-1:0]  lateral_scale,
`endif
    input  logic [WIDTH-1:0]  threshold,
    input  logic [WIDTH-1:0]  decay,
    input  logic [REFR_W-1:0] refr_period,
    input  logic [WIDTH-1:0]  self_scale,
    output logic [WIDTH-1:0]  mem_next,
    output logic [REFR_W-1:0] refr_next,
    output logic              spike
);

    // Wide enough to hold leak + ext + self + lateral*count without wrapping.
    localparam int SUM_W = WIDTH + CNT_W + 2;

    logic [SUM_W-1:0] leak;
    logic [SUM_W-1:0] lat_term;
    logic [SUM_W-1:0] in_sum;
    logic [WIDTH-1:0] sum_sat;

    // Leak, integrate, saturate, then fire or hold; refractory neurons ignore input.
    always_comb begin
        leak      = '0;
        lat_term  = '0;
        mem_next  = mem;
        refr_next = refr;
        spike     = 1'b0;
        if (mem > decay) leak = SUM_W'(mem - decay);
`ifdef RSNN_LATERAL_EN
        lat_term  = SUM_W'(lateral_scale) * SUM_W'(lat_count);
`endif
        in_sum    = SUM_W'(ext) + (prev_spike ? SUM_W'(self_scale) : SUM_W'(0)) + lat_term;
        sum_sat   = WIDTH'(sat_add(32'(leak), 32'(in_sum), WIDTH));
        if (refr != '0) begin
            refr_next = refr - REFR_W'(1);
            mem_next  = '0;
        end else if (sum_sat >= threshold) begin
            spike     = 1'b1;
            mem_next  = '0;
            refr_next = refr_period;
        end else begin
            mem_next  = sum_sat;
        end
    end

endmodule

// File: rtl/rsnn_layer.sv
// N-neuron recurrent spiking layer with one time-multiplexed update datapath.
// Each accepted tick sweeps neurons 0..N-1 (one per cycle), then publishes
// the spike vector. Define RSNN_LATERAL_EN to compile in lateral feedback.
module rsnn_layer
    import rsnn_pkg::*;
#(
    parameter int N_NEURONS = 4,
    parameter int WIDTH     = 8,
    parameter int REFR_W    = 8
) (
    input logic   clk,
    input logic   reset,
    rsnn_if.slave bus
);

    localparam int IDX_W = $clog2(N_NEURONS);
    localparam int CNT_W = $clog2(N_NEURONS + 1);

    rsnn_state_e                state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [WIDTH-1:0]           mem_q [N_NEURONS];
    logic [WIDTH-1:0]           mem_d [N_NEURONS];
    logic [REFR_W-1:0]          refr_q [N_NEURONS];
    logic [REFR_W-1:0]          refr_d [N_NEURONS];
    logic [N_NEURONS-1:0]       prev_q, prev_d;
    logic [N_NEURONS-1:0]       acc_q, acc_d;
    logic [N_NEURONS*WIDTH-1:0] ext_q, ext_d;
    logic [WIDTH-1:0]           thr_q, thr_d;
    logic [WIDTH-1:0]           decay_q, decay_d;
    logic [REFR_W-1:0]          rper_q, rper_d;
    logic [WIDTH-1:0]           self_q, self_d;
    logic [N_NEURONS-1:0]       spike_out_q, spike_out_d;
    logic                       spike_valid_q, spike_valid_d;
    logic                       overrun_q, overrun_d;

    logic [WIDTH-1:0]           nu_mem;
    logic [REFR_W-1:0]          nu_refr;
    logic                       nu_spike;

`ifdef RSNN_LATERAL_EN
    logic [WIDTH-1:0]           lat_q, lat_d;
    logic [N_NEURONS-1:0]       lat_mask;
    logic [CNT_W-1:0]           lat_count;

    // Count the other neurons that fired last timestep, excluding the current one.
    always_comb begin
        lat_mask          = prev_q;
        lat_mask[idx_q]   = 1'b0;
        lat_count         = CNT_W'(popcount(32'(lat_mask), N_NEURONS));
    end
`endif

    rsnn_neuron_update #(
        .WIDTH  (WIDTH),
        .REFR_W (REFR_W),
        .CNT_W  (CNT_W)
    ) u_update (
        .mem           (mem_q[idx_q]),
        .refr          (refr_q[idx_q]),
        .ext           (ext_q[idx_q*WIDTH +: WIDTH]),
        .prev_spike    (prev_q[idx_q]),
`ifdef RSNN_LATERAL_EN
        .lat_count     (lat_count),
        .lateral_scale (lat_q),
`endif
        .threshold     (thr_q),
        .decay         (decay_q),
        .refr_period   (rper_q),
        .self_scale    (self_q),
        .mem_next      (nu_mem),
        .refr_next     (nu_refr),
        .spike         (nu_spike)
    );

    // Sweep control: accept a tick, step through neurons, publish, flag dropped ticks.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        mem_d         = mem_q;
        refr_d        = refr_q;
        prev_d        = prev_q;
        acc_d         = acc_q;
        ext_d         = ext_q;
        thr_d         = thr_q;
        decay_d       = decay_q;
        rper_d        = rper_q;
        self_d        = self_q;
        spike_out_d   = spike_out_q;
        spike_valid_d = 1'b0;
        overrun_d     = overrun_q;
`ifdef RSNN_LATERAL_EN
        lat_d         = lat_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.tick && bus.enable) begin
                    state_d = UPDATE;
                    idx_d   = '0;
                    acc_d   = '0;
                    ext_d   = bus.ext_current;
                    thr_d   = bus.threshold;
                    decay_d = bus.decay;
                    rper_d  = bus.refractory_period;
                    self_d  = bus.self_scale;
`ifdef RSNN_LATERAL_EN
                    lat_d   = bus.lateral_scale;
`endif
                end
            end
            UPDATE: begin
                if (bus.tick) overrun_d = 1'b1;
                mem_d[idx_q]  = nu_mem;
                refr_d[idx_q] = nu_refr;
                acc_d[idx_q]  = nu_spike;
                if (idx_q == IDX_W'(N_NEURONS - 1)) begin
                    state_d       = DONE;
                    spike_out_d   = acc_d;
                    prev_d        = acc_d;
                    spike_valid_d = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (bus.tick) overrun_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any sweep in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            mem_q         <= '{default: '0};
            refr_q        <= '{default: '0};
            prev_q        <= '0;
            acc_q         <= '0;
            ext_q         <= '0;
            thr_q         <= '0;
            decay_q       <= '0;
            rper_q        <= '0;
            self_q        <= '0;
            spike_out_q   <= '0;
            spike_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
`ifdef RSNN_LATERAL_EN
            lat_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            mem_q         <= mem_d;
            refr_q        <= refr_d;
            prev_q        <= prev_d;
            acc_q         <= acc_d;
            ext_q         <= ext_d;
            thr_q         <= thr_d;
            decay_q       <= decay_d;
            rper_q        <= rper_d;
            self_q        <= self_d;
            spike_out_q   <= spike_out_d;
            spike_valid_q <= spike_valid_d;
            overrun_q     <= overrun_d;
`ifdef RSNN_LATERAL_EN
            lat_q         <= lat_d;
`endif
        end
    end

    assign bus.spike_out   = spike_out_q;
    assign bus.spike_valid = spike_valid_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_rsnn_layer.sv
// Scoreboard bench for rsnn_layer (N=4, WIDTH=8). Expected spike vectors are
// queued when a tick is issued and popped by a monitor on every spike_valid.
module tb_rsnn_layer;

    localparam int N = 4;
    localparam int W = 8;

`ifdef RSNN_LATERAL_EN
    localparam logic [N-1:0] LAT_EXP = 4'b1110;
`else
    localparam logic [N-1:0] LAT_EXP = 4'b0000;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [N-1:0] exp_q [$];

    rsnn_if #(.N_NEURONS(N), .WIDTH(W), .REFR_W(8)) bus ();

    rsnn_layer #(.N_NEURONS(N), .WIDTH(W), .REFR_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N*W-1:0] ext, input logic [7:0] thr, input logic [7:0] dec,
                                 input logic [7:0] rper, input logic [7:0] self_s, input logic [7:0] lat_s);
        bus.ext_current       = ext;
        bus.threshold         = thr;
        bus.decay             = dec;
        bus.refractory_period = rper;
        bus.self_scale        = self_s;
        bus.lateral_scale     = lat_s;
    endtask

    task automatic waitIdle();
        int c = 0;
        while (bus.busy && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        if (bus.busy) begin
            checks++;
            errors++;
            $display("[TB] FAIL busy_timeout actual=1 expected=0");
        end
    endtask

    // Issue one tick and let the timestep finish; the monitor checks the result.
    task automatic runTick(input logic [N-1:0] expected);
        exp_q.push_back(expected);
        @(posedge clk); #1 bus.tick = 1'b1;
        @(posedge clk); #1 bus.tick = 1'b0;
        waitIdle();
    endtask

    task automatic doReset(input string tag);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput({tag, "_spike_out"}, 32'(bus.spike_out), 32'd0);
        checkOutput({tag, "_valid"}, 32'(bus.spike_valid), 32'd0);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, "_overrun"}, 32'(bus.overrun), 32'd0);
        reset = 1'b0;
    endtask

    // Scoreboard monitor: compare every published spike vector against the queue.
    always @(negedge clk) begin
        if (bus.spike_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_spike_valid actual=%b expected=none", bus.spike_out);
            end else begin
                checkOutput("spike_out", 32'(bus.spike_out), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.enable = 1'b1;
        bus.tick   = 1'b0;
        applyStimulus('0, 8'd50, 8'd10, 8'd2, 8'd0, 8'd0);
        doReset("reset0");

        // Strong drive: every neuron fires in the first timestep; check timing.
        applyStimulus({N{8'd60}}, 8'd50, 8'd10, 8'd2, 8'd0, 8'd0);
        exp_q.push_back(4'b1111);
        @(posedge clk); #1 bus.tick = 1'b1;
        @(posedge clk); #1 bus.tick = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checkOutput("t1_busy", 32'(bus.busy), 32'd1);
            checkOutput("t1_valid", 32'(bus.spike_valid), (k == 4) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
        end
        checkOutput("t1_busy_end", 32'(bus.busy), 32'd0);
        checkOutput("t1_hold", 32'(bus.spike_out), 32'hF);

        // Refractory for two timesteps, then integrate 40, then leak to 30 + 40.
        applyStimulus({N{8'd40}}, 8'd50, 8'd10, 8'd2, 8'd0, 8'd0);
        runTick(4'b0000);
        runTick(4'b0000);
        runTick(4'b0000);
        runTick(4'b1111);

        // Tick re-pulsed mid-sweep is dropped and latches overrun.
        applyStimulus({N{8'd0}}, 8'd50, 8'd10, 8'd2, 8'd0, 8'd0);
        exp_q.push_back(4'b0000);
        @(posedge clk); #1 bus.tick = 1'b1;
        @(posedge clk); #1 bus.tick = 1'b0;
        checkOutput("t3_overrun_before", 32'(bus.overrun), 32'd0);
        @(posedge clk); #1 bus.tick = 1'b1;
        @(posedge clk); #1 bus.tick = 1'b0;
        checkOutput("t3_overrun_set", 32'(bus.overrun), 32'd1);
        checkOutput("t3_busy_mid", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("t3_valid_on_time", 32'(bus.spike_valid), 32'd1);
        waitIdle();

        // Disabled tick in IDLE: ignored, overrun untouched.
        bus.enable = 1'b0;
        @(posedge clk); #1 bus.tick = 1'b1;
        @(posedge clk); #1 bus.tick = 1'b0;
        checkOutput("t3_dis_busy", 32'(bus.busy), 32'd0);
        checkOutput("t3_dis_overrun", 32'(bus.overrun), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t3_dis_busy_late", 32'(bus.busy), 32'd0);
        bus.enable = 1'b1;

        // Lateral feedback: neuron 0 fires, then drives the others through lat=50.
        doReset("reset4");
        applyStimulus({8'd0, 8'd0, 8'd0, 8'd60}, 8'd50, 8'd10, 8'd0, 8'd0, 8'd50);
        runTick(4'b0001);
        applyStimulus({N{8'd0}}, 8'd50, 8'd10, 8'd0, 8'd0, 8'd50);
        runTick(LAT_EXP);

        // Saturation: 255 + 255 must clamp to 255 (not wrap to 254) and still fire.
        doReset("reset5");
        applyStimulus({N{8'd255}}, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0);
        runTick(4'b1111);
        runTick(4'b1111);
        // Reset mid-sweep: nothing published for the aborted timestep.
        @(posedge clk); #1 bus.tick = 1'b1;
        @(posedge clk); #1 bus.tick = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        checkOutput("t5_abort_spike_out", 32'(bus.spike_out), 32'd0);
        checkOutput("t5_abort_valid", 32'(bus.spike_valid), 32'd0);
        checkOutput("t5_abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("t5_abort_overrun", 32'(bus.overrun), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("t5_abort_idle", 32'(bus.busy), 32'd0);

        // Zero threshold fires every tick; refractory 3 gives one spike per 4 ticks.
        applyStimulus({N{8'd0}}, 8'd0, 8'd10, 8'd0, 8'd0, 8'd0);
        for (int t = 0; t < 3; t++) runTick(4'b1111);
        applyStimulus({N{8'd0}}, 8'd0, 8'd10, 8'd3, 8'd0, 8'd0);
        runTick(4'b1111);
        runTick(4'b0000);
        runTick(4'b0000);
        runTick(4'b0000);
        runTick(4'b1111);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
